// File: rtl/bus_drive_arbiter.sv
// bus_drive_arbiter: round-robin owner selection for a bank of Buffer32_32
// tri-state drivers sharing one 32-bit internal bus. At most one Sel line is
// high at any time, and every change of owner passes through one all-low cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus free, arbitrate REQ from PTR on every edge
// GRANT   | SEL drives OWNER's buffer; watch for release or hold expiry
// TURN    | one all-low turnaround cycle; arbitrates again on its exit edge
module bus_drive_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] SEL,
    output logic [IDX_W-1:0] OWNER,
    output logic             BUSY,
    output logic             FORCED
);

    // The hold timer counts down the grant cycles still allowed before a
    // waiting requester may force a handover; it reaches zero on the
    // MAX_HOLD-th grant cycle.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam bit HOLD_LIMITED = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_left;
    logic             armed;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             other_req;

    // First requester at or after start, with wrap modulo N_REQ.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] start);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic               found;
        int                 off;
        int                 pos;
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> start);
        found = 1'b0;
        off   = 0;
        // Scan downward so the lowest offset from start wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        pos = int'(start) + off;
        if (pos >= N_REQ) begin
            pos = pos - N_REQ;
        end
        return {found, IDX_W'(pos)};
    endfunction

    // Index after idx, wrapping at N_REQ rather than at 2**IDX_W.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        int n;
        n = int'(idx) + 1;
        if (n >= N_REQ) begin
            n = 0;
        end
        return IDX_W'(n);
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Arbitration result and "someone else is waiting", both from the live REQ.
    always_comb begin
        {pick_valid, pick_idx} = rr_pick(REQ, ptr);
        other_req              = |(REQ & ~SEL);
    end

    // Arbiter FSM. Every output is a flop, so REQ never reaches SEL through
    // logic alone.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            SEL       <= '0;
            OWNER     <= '0;
            BUSY      <= 1'b0;
            FORCED    <= 1'b0;
            ptr       <= '0;
            hold_left <= '0;
            armed     <= 1'b0;
        end else begin
            FORCED <= 1'b0;
            // The first edge after reset release only arms the arbiter, so a
            // release that lands near an edge never produces a runt grant.
            armed  <= 1'b1;
            case (state)
                // TURN shares the IDLE arbitration so the owner-to-owner gap
                // is a single all-low cycle.
                ST_IDLE, ST_TURN: begin
                    if (armed && pick_valid) begin
                        SEL       <= to_onehot(pick_idx);
                        OWNER     <= pick_idx;
                        BUSY      <= 1'b1;
                        hold_left <= HOLD_LOAD;
                        state     <= ST_GRANT;
                    end else begin
                        SEL   <= '0;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!REQ[OWNER]) begin
                        SEL   <= '0;
                        BUSY  <= 1'b0;
                        ptr   <= next_idx(OWNER);
                        state <= ST_TURN;
                    end else if (HOLD_LIMITED && (hold_left == '0) && other_req) begin
                        SEL    <= '0;
                        BUSY   <= 1'b0;
                        FORCED <= 1'b1;
                        ptr    <= next_idx(OWNER);
                        state  <= ST_TURN;
                    end else if (hold_left != '0) begin
                        // A lone owner just stays at zero, i.e. saturated.
                        hold_left <= hold_left - 1'b1;
                    end
                end
                default: begin
                    SEL   <= '0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Bench for bus_drive_arbiter with N_REQ=4, MAX_HOLD=4. Vectors carry the
// REQ value to drive plus the outputs expected after the following rising
// edge; expectations go into a queue at drive time and are compared at the
// next falling edge.
module tb_bus_drive_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 2;

    logic             Clk;
    logic             Reset_n;
    logic [N_REQ-1:0] REQ;
    logic [N_REQ-1:0] SEL;
    logic [IDX_W-1:0] OWNER;
    logic             BUSY;
    logic             FORCED;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] sel;
        logic [IDX_W-1:0] owner;
        logic             busy;
        logic             forced;
        string            name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    bus_drive_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_HOLD(MAX_HOLD),
        .IDX_W   (IDX_W)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .REQ    (REQ),
        .SEL    (SEL),
        .OWNER  (OWNER),
        .BUSY   (BUSY),
        .FORCED (FORCED)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] sel,
                       input logic [IDX_W-1:0] owner, input logic busy,
                       input logic forced, input string name);
        vec_t v;
        v.req    = req;
        v.sel    = sel;
        v.owner  = owner;
        v.busy   = busy;
        v.forced = forced;
        v.name   = name;
        vecs.push_back(v);
    endtask

    task automatic compare(input vec_t e);
        logic [IDX_W-1:0] own_act;
        own_act = e.busy ? OWNER : '0;
        n_checks++;
        if ({SEL, own_act, BUSY, FORCED} === {e.sel, e.owner, e.busy, e.forced}) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got sel=%b owner=%0d busy=%b forced=%b, want sel=%b owner=%0d busy=%b forced=%b",
                     e.name, $time, SEL, OWNER, BUSY, FORCED, e.sel, e.owner, e.busy, e.forced);
        end
    endtask

    // Called just after a falling edge: drive, let one rising edge pass,
    // then score at the next falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        REQ = v.req;
        exp_q.push_back(v);
        @(posedge Clk);
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty @%0t: got 0 entries, want 1", $time);
        end else begin
            e = exp_q.pop_front();
            compare(e);
        end
    endtask

    task automatic step_args(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] sel,
                             input logic [IDX_W-1:0] owner, input logic busy,
                             input logic forced, input string name);
        vec_t v;
        v.req    = req;
        v.sel    = sel;
        v.owner  = owner;
        v.busy   = busy;
        v.forced = forced;
        v.name   = name;
        step(v);
    endtask

    initial begin
        logic [N_REQ-1:0] one;
        one = 4'b0001;

        // Reset release with everyone requesting: one arming edge, then owner 0.
        add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "post_reset_arm");
        // Round robin under continuous load: 0,1,2,3,0, four cycles each,
        // one FORCED gap between owners.
        for (int g = 0; g < 5; g++) begin
            if (g > 0) add(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "rr_forced_gap");
            for (int c = 0; c < 4; c++) begin
                add(4'b1111, one << (g % 4), IDX_W'(g % 4), 1'b1, 1'b0, "rr_grant");
            end
        end
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_release_turn");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");
        // Single requester 1 for three cycles, then release.
        for (int c = 0; c < 3; c++) add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "req1_grant");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "req1_turn");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "req1_idle_a");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "req1_idle_b");
        // Lone requester 2 well past MAX_HOLD: keeps the bus, never forced.
        for (int c = 0; c < 20; c++) add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_hold");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "lone_turn");
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "lone_idle");
        // Owner 3 releases while 0 waits: pointer wraps to 0.
        add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "wrap_grant3");
        add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "wrap_hold3");
        add(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_turn");
        add(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap_pick0");
        // Same requester drops and re-requests: still one TURN cycle.
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rereq_turn");
        add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "rereq_grant");
        add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "rereq_hold");

        Reset_n = 1'b0;
        REQ     = 4'b1111;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({SEL, OWNER, BUSY, FORCED} === 8'b0) n_pass++;
        else $display("FAIL reset_state: got sel=%b owner=%0d busy=%b forced=%b, want all zero",
                      SEL, OWNER, BUSY, FORCED);

        Reset_n = 1'b1;
        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset in the middle of a grant, between clock edges.
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (SEL === 4'b0000 && BUSY === 1'b0 && OWNER === 2'd0 && FORCED === 1'b0) n_pass++;
        else $display("FAIL async_reset: got sel=%b owner=%0d busy=%b, want sel=0000 owner=0 busy=0",
                      SEL, OWNER, BUSY);
        @(negedge Clk);
        Reset_n = 1'b1;
        // Pointer was 1 before reset; a restart from 0 must choose 0 over 3.
        step_args(4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, "rst2_arm");
        for (int c = 0; c < 4; c++) step_args(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "rst2_grant0");
        step_args(4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1, "rst2_forced_gap");
        step_args(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "rst2_grant3");
        step_args(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst2_turn");
        step_args(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst2_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
